spdif_tx: RTL

//  Parametrised S/PDIF (IEC 60958 consumer) transmitter: accepts stereo sample pairs over a valid/ready

---
 rtl/spdif_pkg.sv | 13 +
 rtl/spdif_if.sv | 9 +
 rtl/spdif_bmc_ser.sv | 39 +++
 rtl/spdif_tx.sv | 98 +++++++++
 4 files changed

// File: rtl/spdif_pkg.sv
// spdif_pkg: shared constants and types for the S/PDIF transmitter.
package spdif_pkg;
    localparam int SUBFRAME_CELLS = 64;
    localparam int SUBFRAMES_PER_BLOCK = 384;
    localparam logic [7:0] PRE_B = 8'b10011100;
    localparam logic [7:0] PRE_M = 8'b10010011;
    localparam logic [7:0] PRE_W = 8'b10010110;
    localparam int SLOT_V = 28;
    localparam int SLOT_U = 29;
    localparam int SLOT_C = 30;
    localparam int SLOT_P = 31;
    typedef logic [SUBFRAME_CELLS-1:0] cells_t;
endpackage

// File: rtl/spdif_if.sv
// spdif_if: stereo sample-pair valid/ready handshake into the transmitter.
interface spdif_if #(parameter int SAMPLE_W = 16);
    logic [SAMPLE_W-1:0] in_left;
    logic [SAMPLE_W-1:0] in_right;
    logic in_valid;
    logic in_ready;
    modport master(output in_left, in_right, in_valid, input in_ready);
    modport slave(input in_left, in_right, in_valid, output in_ready);
endinterface

// File: rtl/spdif_bmc_ser.sv
// spdif_bmc_ser: 64-cell shift register; each tick toggles the line when the outgoing cell is 1.
module spdif_bmc_ser
    import spdif_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  logic   tick,
    input  cells_t vec,
    output logic   out
);
    cells_t sh_q, sh_d;
    logic out_q, out_d;

    // A load is also a tick: cell 0 goes out on the same edge it is loaded.
    always_comb begin
        sh_d = sh_q;
        out_d = out_q;
        if (load) begin
            out_d = out_q ^ vec[SUBFRAME_CELLS-1];
            sh_d = {vec[SUBFRAME_CELLS-2:0], 1'b0};
        end else if (tick) begin
            out_d = out_q ^ sh_q[SUBFRAME_CELLS-1];
            sh_d = {sh_q[SUBFRAME_CELLS-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q <= '0;
            out_q <= 1'b0;
        end else begin
            sh_q <= sh_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;
endmodule

// File: rtl/spdif_tx.sv
// spdif_tx: S/PDIF consumer transmitter; divider, subframe/block counters, handshake,
// channel-status latch and subframe vector composition feeding the BMC serializer.
module spdif_tx
    import spdif_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    spdif_if.slave      sin,
    input  logic [31:0] cs_word,
    input  logic        user_bit,
    output logic        underrun,
    output logic        block_start,
    output logic        spdif_out
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic [5:0] cell_q, cell_d;
    logic [8:0] sf_q, sf_d;
    logic [SAMPLE_W-1:0] hold_q, hold_d;
    logic hold_v_q, hold_v_d;
    logic [31:0] cs_q, cs_d;
    logic tick, load, left, v, c;
    logic [7:0] frame;
    logic [31:0] cs_eff;
    logic [SAMPLE_W-1:0] samp;
    logic [31:4] slots;
    cells_t vec;

    assign tick = en && !reset && div_q == '0;
    assign load = tick && cell_q == '0;
    assign left = !sf_q[0];
    assign sin.in_ready = load && left;
    assign block_start = load && sf_q == '0;
    assign underrun = load && left && !sin.in_valid;

    always_comb begin
        div_d = (!en || div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        cell_d = !en ? '0 : tick ? cell_q + 6'd1 : cell_q;
        sf_d = !en ? '0 : !load ? sf_q : sf_q == 9'(SUBFRAMES_PER_BLOCK - 1) ? '0 : sf_q + 9'd1;
        hold_d = !en ? '0 : sin.in_ready ? (sin.in_valid ? sin.in_right : '0) : hold_q;
        hold_v_d = !en ? 1'b0 : sin.in_ready ? !sin.in_valid : hold_v_q;
        cs_eff = block_start ? cs_word : cs_q;
        cs_d = cs_eff;
    end

    // Right subframe replays the pair (or the underrun zero) captured at the left load.
    always_comb begin
        frame = sf_q[8:1];
        c = frame < 8'd32 ? cs_eff[frame[4:0]] : 1'b0;
        v = left ? !sin.in_valid : hold_v_q;
        samp = left ? (sin.in_valid ? sin.in_left : '0) : hold_q;
        slots = '0;
        slots[27:4] = 24'(samp) << (24 - SAMPLE_W);
        slots[SLOT_V] = v;
        slots[SLOT_U] = user_bit;
        slots[SLOT_C] = c;
        slots[SLOT_P] = ^slots[SLOT_C:4];
        vec = '0;
        vec[63:56] = sf_q == '0 ? PRE_B : left ? PRE_M : PRE_W;
        for (int s = 4; s < 32; s++) begin
            vec[55 - 2 * (s - 4)] = 1'b1;
            vec[54 - 2 * (s - 4)] = slots[s];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
            cell_q <= '0;
            sf_q <= '0;
            hold_q <= '0;
            hold_v_q <= 1'b0;
            cs_q <= '0;
        end else begin
            div_q <= div_d;
            cell_q <= cell_d;
            sf_q <= sf_d;
            hold_q <= hold_d;
            hold_v_q <= hold_v_d;
            cs_q <= cs_d;
        end
    end

    spdif_bmc_ser u_ser (
        .clk(clk),
        .reset(reset),
        .load(load),
        .tick(tick),
        .vec(vec),
        .out(spdif_out)
    );
endmodule
